// File: rtl/key_debounce_pkg.sv
// key_pkg: shared FSM states and board constants for the key debouncer
package key_pkg;
    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_PRESS_WAIT,
        KEY_PRESSED,
        KEY_RELEASE_WAIT
    } key_state_t;
    localparam int NUM_KEYS = 4;
    localparam int DEBOUNCE_CYCLES_50MHZ = 1_000_000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel (sync, debounce FSM, pulses, LED toggle); KEY_DEBOUNCE_RELEASE_EN adds o_release
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
`ifdef KEY_DEBOUNCE_RELEASE_EN
    output logic o_release,
`endif
    output logic o_led
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    key_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_led;
    key_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_key_s;
`ifdef KEY_DEBOUNCE_RELEASE_EN
    logic          r_release;
    logic          w_release_nxt;
    assign o_release = r_release;
`endif

    assign w_key_s = r_sync[1];
    assign o_level = r_level;
    assign o_press = r_press;
    assign o_led   = r_led;

    // State, counter and registered outputs; LED flips on the press edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= KEY_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_led   <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
            r_release <= 1'b0;
`endif
        end else begin
            r_sync  <= {r_sync[0], ~i_key};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_press <= w_press_nxt;
            r_led   <= r_led ^ w_press_nxt;
`ifdef KEY_DEBOUNCE_RELEASE_EN
            r_release <= w_release_nxt;
`endif
        end
    end

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES+1 steady samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_press_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
        w_release_nxt = 1'b0;
`endif
        case (r_state)
            KEY_IDLE: begin
                if (w_key_s) begin
                    w_state_nxt = KEY_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!w_key_s) begin
                    w_state_nxt = KEY_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = KEY_PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            KEY_PRESSED: begin
                if (!w_key_s) begin
                    w_state_nxt = KEY_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (w_key_s) begin
                    w_state_nxt = KEY_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = KEY_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
                    w_release_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = KEY_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: four independent debounced key channels; KEY_DEBOUNCE_RELEASE_EN adds key_release
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
`ifdef KEY_DEBOUNCE_RELEASE_EN
    output logic [3:0] key_release,
`endif
    output logic [0:3] led
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_key    (key[i]),
            .o_level  (key_level[i]),
            .o_press  (key_press[i]),
`ifdef KEY_DEBOUNCE_RELEASE_EN
            .o_release(key_release[i]),
`endif
            .o_led    (led[i])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random stimulus against a run-length reference model
module tb_key_debounce;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [0:3] led;
`ifdef KEY_DEBOUNCE_RELEASE_EN
    logic [3:0] key_release;
`endif

    logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
    logic [0:3] m_led = '0;
    int         m_run [4] = '{0, 0, 0, 0};
    int         n_vec = 0;
    int         n_bad = 0;
    int         hold [4] = '{0, 0, 0, 0};

    key_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_level  (key_level),
        .key_press  (key_press),
`ifdef KEY_DEBOUNCE_RELEASE_EN
        .key_release(key_release),
`endif
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A change is accepted once the synchronised key has disagreed with the
    // debounced level for D+1 consecutive samples
    task automatic step();
        logic [3:0] s;
        @(posedge clk);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_led = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = ~key;
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < 4; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_run[i] = 0;
                        m_lvl[i] = s[i];
                        if (s[i]) begin
                            m_press[i] = 1'b1;
                            m_led[i] = ~m_led[i];
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        #1;
        chk("key_level", key_level, m_lvl);
        chk("key_press", key_press, m_press);
        chk("led", led, m_led);
`ifdef KEY_DEBOUNCE_RELEASE_EN
        chk("key_release", key_release, m_rel);
`endif
    endtask

    task automatic steps(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic latency(input string tag, input int idx);
        int t = 0;
        for (int c = 1; c <= 20 && t == 0; c++) begin
            step();
            if (key_press[idx]) t = c;
        end
        chk_int(tag, t, D + 3);
    endtask

    initial begin
        steps(3);
        rst = 1'b0;
        latency("reset_hold_latency", 3);
        steps(4);
        key = 4'b1111;
        steps(12);
        key = 4'b1110;
        latency("clean_press_latency", 0);
        steps(4);
        key = 4'b1111;
        steps(12);
        key = 4'b1101;
        steps(3);
        key = 4'b1111;
        steps(2);
        key = 4'b1101;
        latency("bounce_final_latency", 1);
        key = 4'b1111;
        steps(12);
        key = 4'b1011;
        steps(10);
        key = 4'b1111;
        steps(10);
        key = 4'b1011;
        steps(10);
        key = 4'b1111;
        steps(12);
        key = 4'b0110;
        latency("simul_press_latency", 0);
        key = 4'b1111;
        steps(12);
        key = 4'b0110;
        steps(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        latency("post_reset_latency", 3);
        key = 4'b1111;
        steps(12);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    key[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        steps(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
